// File: rtl/wbm_swmirror.sv
// Wishbone B4 pipelined master that reads the spio switch byte and writes it
// back to the LEDs with a masked write, on an interrupt edge or a periodic poll.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | cyc low; waits for a trigger or a pending trigger
// S_RD_REQ  | read strobe to the spio register, held while stalled
// S_RD_WAIT | read accepted; waiting for ack (captures the status word)
// S_WR_REQ  | masked LED write strobe, held while stalled
// S_WR_WAIT | write accepted; waiting for ack (bumps the pair counter)
module wbm_swmirror #(
   parameter int             AW          = 30,
   parameter logic [AW-1:0]  SPIO_ADDR   = '0,
   parameter logic [7:0]     LED_MASK    = 8'hff,
   parameter int             TIMEOUT     = 1023,
   parameter int             POLL_PERIOD = 0
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_en,
   input  logic          i_int,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [31:0]   o_wb_data,
   output logic [3:0]    o_wb_sel,
   input  logic          i_wb_stall,
   input  logic          i_wb_ack,
   input  logic          i_wb_err,
   input  logic [31:0]   i_wb_data,
   output logic          o_busy,
   output logic [31:0]   o_status,
   output logic          o_err,
   output logic [15:0]   o_count
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WR_WAIT
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    rst_sync;
   logic          ready;
   logic          last_int;
   logic          pending;
   logic          poll_tick;
   logic          trigger;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          start;
   logic          capture;
   logic          done;
   logic          abort;

   // Release of reset is re-timed so the FSM never starts on the release edge.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) rst_sync <= 2'b00;
      else            rst_sync <= {rst_sync[0], 1'b1};
   end
   assign ready = rst_sync[1];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) last_int <= 1'b0;
      else            last_int <= i_int;
   end

   generate
      if (POLL_PERIOD > 0) begin : g_poll
         localparam int PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
         logic [PW-1:0] poll_cnt;

         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n)                 poll_cnt <= '0;
            else if (i_en) begin
               if (poll_cnt == '0)          poll_cnt <= PW'(POLL_PERIOD - 1);
               else                         poll_cnt <= poll_cnt - 1'b1;
            end
         end
         assign poll_tick = i_en && (poll_cnt == '0);
      end else begin : g_no_poll
         assign poll_tick = 1'b0;
      end
   endgenerate

   assign trigger = i_en & ((i_int & ~last_int) | poll_tick);
   assign tmo_hit = (tmo_cnt == '0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      capture   = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         S_IDLE: begin
            if (ready && (trigger || pending)) begin
               start     = 1'b1;
               state_nxt = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (i_wb_err)                     abort = 1'b1;
            else if (!i_wb_stall && i_wb_ack) begin
               capture   = 1'b1;
               state_nxt = S_WR_REQ;
            end
            else if (!i_wb_stall)             state_nxt = S_RD_WAIT;
            else if (tmo_hit)                 abort = 1'b1;
         end
         S_RD_WAIT: begin
            if (i_wb_err)                     abort = 1'b1;
            else if (i_wb_ack) begin
               capture   = 1'b1;
               state_nxt = S_WR_REQ;
            end
            else if (tmo_hit)                 abort = 1'b1;
         end
         S_WR_REQ: begin
            if (i_wb_err)                     abort = 1'b1;
            else if (!i_wb_stall && i_wb_ack) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
            else if (!i_wb_stall)             state_nxt = S_WR_WAIT;
            else if (tmo_hit)                 abort = 1'b1;
         end
         S_WR_WAIT: begin
            if (i_wb_err)                     abort = 1'b1;
            else if (i_wb_ack) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
            else if (tmo_hit)                 abort = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   // Down-counter reloads on every state change and while idle; reaching zero
   // in the same bus state means TIMEOUT cycles passed without a response.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)                                 tmo_cnt <= '0;
      else if (state == S_IDLE || state_nxt != state) tmo_cnt <= TW'(TIMEOUT - 1);
      else if (!tmo_hit)                              tmo_cnt <= tmo_cnt - 1'b1;
   end

   // Triggers seen while busy (or before reset sync completes) collapse into one.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)   pending <= 1'b0;
      else if (start)   pending <= 1'b0;
      else if (trigger) pending <= 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_status <= '0;
         o_count  <= '0;
         o_err    <= 1'b0;
      end else begin
         o_err <= abort;
         if (capture) o_status <= i_wb_data;
         if (done)    o_count  <= o_count + 16'd1;
      end
   end

   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_addr = '0;
      o_wb_data = '0;
      o_wb_sel  = 4'h0;
      case (state)
         S_RD_REQ, S_RD_WAIT: begin
            o_wb_cyc  = 1'b1;
            o_wb_stb  = (state == S_RD_REQ);
            o_wb_addr = SPIO_ADDR;
            o_wb_sel  = 4'hf;
         end
         S_WR_REQ, S_WR_WAIT: begin
            o_wb_cyc  = 1'b1;
            o_wb_stb  = (state == S_WR_REQ);
            o_wb_we   = 1'b1;
            o_wb_addr = SPIO_ADDR;
            o_wb_sel  = 4'b0011;
            o_wb_data = {16'h0000, LED_MASK, o_status[23:16]};
         end
         default: ;
      endcase
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_wbm_swmirror.sv
// Directed bench for wbm_swmirror: a hand-driven responder on one instance,
// an auto-acking responder on a second instance with the periodic poll on.
module tb_wbm_swmirror;

   logic        clk;
   logic        rst_n;
   logic        en, intr;
   logic        cyc, stb, we;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic [3:0]  sel;
   logic        stall, ack, err;
   logic [31:0] rdata;
   logic        busy, err_o;
   logic [31:0] status;
   logic [15:0] count;

   logic        en_p;
   logic        cyc_p, stb_p, we_p;
   logic [29:0] addr_p;
   logic [31:0] wdata_p;
   logic [3:0]  sel_p;
   logic        ack_p;
   logic        busy_p, err_o_p;
   logic [31:0] status_p;
   logic [15:0] count_p;

   int checks   = 0;
   int failures = 0;
   int rd_n     = 0;
   int wr_n     = 0;
   int cyc_num  = 0;
   int starts_p = 0;
   int last_start = 0;
   int prev_start = 0;
   logic cyc_p_d = 1'b0;

   wbm_swmirror #(.AW(30), .SPIO_ADDR(30'h5), .LED_MASK(8'hff), .TIMEOUT(8), .POLL_PERIOD(0)) u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_int(intr),
      .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr),
      .o_wb_data(wdata), .o_wb_sel(sel),
      .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err), .i_wb_data(rdata),
      .o_busy(busy), .o_status(status), .o_err(err_o), .o_count(count)
   );

   wbm_swmirror #(.AW(30), .SPIO_ADDR(30'h0), .LED_MASK(8'hff), .TIMEOUT(8), .POLL_PERIOD(16)) u_poll (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en_p), .i_int(1'b0),
      .o_wb_cyc(cyc_p), .o_wb_stb(stb_p), .o_wb_we(we_p), .o_wb_addr(addr_p),
      .o_wb_data(wdata_p), .o_wb_sel(sel_p),
      .i_wb_stall(1'b0), .i_wb_ack(ack_p), .i_wb_err(1'b0), .i_wb_data(32'h0042_0000),
      .o_busy(busy_p), .o_status(status_p), .o_err(err_o_p), .o_count(count_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus observers: accepted strobes on the main instance, start times on the poll one.
   always @(posedge clk) begin
      cyc_num <= cyc_num + 1;
      if (cyc && stb && !stall) begin
         if (we) wr_n <= wr_n + 1;
         else    rd_n <= rd_n + 1;
      end
      ack_p   <= cyc_p & stb_p;
      cyc_p_d <= cyc_p;
      if (cyc_p && !cyc_p_d) begin
         starts_p   <= starts_p + 1;
         prev_start <= last_start;
         last_start <= cyc_num;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int s;
      rst_n = 1'b0; en = 1'b0; intr = 1'b0; stall = 1'b0; ack = 1'b0; err = 1'b0;
      rdata = '0; en_p = 1'b0;
      repeat (3) tick;
      chk("rst_busy",   busy,   0);
      chk("rst_cyc",    cyc,    0);
      chk("rst_stb",    stb,    0);
      chk("rst_count",  count,  0);
      chk("rst_status", status, 0);
      chk("rst_err",    err_o,  0);
      rst_n = 1'b1;
      repeat (4) tick;
      en = 1'b1;

      // 1: basic mirror, zero-wait responder
      rdata = 32'h00a5_0000; intr = 1'b1;
      tick;
      chk("t1_cyc",  cyc,  1);
      chk("t1_stb",  stb,  1);
      chk("t1_we",   we,   0);
      chk("t1_addr", addr, 32'h5);
      chk("t1_sel",  sel,  4'hf);
      tick;
      chk("t1_rdwait_stb", stb, 0);
      chk("t1_rdwait_cyc", cyc, 1);
      ack = 1'b1; tick; ack = 1'b0;
      chk("t1_status", status, 32'h00a5_0000);
      chk("t1_wr_we",  we,     1);
      chk("t1_wr_stb", stb,    1);
      chk("t1_wdata",  wdata,  32'h0000_ffa5);
      chk("t1_wsel",   sel,    4'b0011);
      chk("t1_waddr",  addr,   32'h5);
      tick;
      chk("t1_wrwait_cyc", cyc, 1);
      ack = 1'b1; tick; ack = 1'b0;
      chk("t1_cyc_drop", cyc,   0);
      chk("t1_count",    count, 1);
      chk("t1_reads",    rd_n,  1);
      chk("t1_writes",   wr_n,  1);
      intr = 1'b0;

      // stray ack/err while idle
      ack = 1'b1; err = 1'b1; tick; ack = 1'b0; err = 1'b0;
      chk("stray_busy", busy, 0);
      tick;
      chk("stray_err",   err_o, 0);
      chk("stray_count", count, 1);

      // 2: stalls on both request phases
      rdata = 32'h003c_0000; stall = 1'b1; intr = 1'b1;
      tick;
      for (int i = 0; i < 3; i++) begin
         chk("t2_rd_stb",  stb,  1);
         chk("t2_rd_addr", addr, 32'h5);
         tick;
      end
      chk("t2_rd_stb_last", stb, 1);
      stall = 1'b0; intr = 1'b0;
      tick;
      chk("t2_rdwait_stb", stb, 0);
      ack = 1'b1; tick; ack = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t2_wr_stb",   stb,   1);
         chk("t2_wr_we",    we,    1);
         chk("t2_wr_wdata", wdata, 32'h0000_ff3c);
         tick;
      end
      stall = 1'b0;
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      chk("t2_count",   count,  2);
      chk("t2_reads",   rd_n,   2);
      chk("t2_writes",  wr_n,   2);
      chk("t2_status",  status, 32'h003c_0000);

      // 3: error on the read (ack in the same cycle loses to err)
      rdata = 32'h0077_0000; intr = 1'b1;
      tick;
      intr = 1'b0;
      tick;
      ack = 1'b1; err = 1'b1;
      chk("t3_cyc_before", cyc, 1);
      tick;
      ack = 1'b0; err = 1'b0;
      chk("t3_cyc_drop", cyc,   0);
      chk("t3_stb_drop", stb,   0);
      chk("t3_err",      err_o, 1);
      tick;
      chk("t3_err_once", err_o,  0);
      chk("t3_status",   status, 32'h003c_0000);
      chk("t3_count",    count,  2);
      chk("t3_writes",   wr_n,   2);
      chk("t3_busy",     busy,   0);

      // 4: responder hangs; a trigger during the hang replays once afterwards
      rdata = 32'h0011_0000; intr = 1'b1;
      tick;
      intr = 1'b0;
      tick;
      n = 0;
      while (cyc === 1'b1 && n < 50) begin
         if (n == 1) intr = 1'b1;
         if (n == 3) intr = 1'b0;
         tick;
         n++;
      end
      chk("t4_hang_len", n,      8);
      chk("t4_err",      err_o,  1);
      chk("t4_count",    count,  2);
      chk("t4_status",   status, 32'h003c_0000);
      tick;
      chk("t4_replay_cyc", cyc,   1);
      chk("t4_err_once",   err_o, 0);
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      chk("t4_wdata", wdata, 32'h0000_ff11);
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      chk("t4_count_after", count, 3);
      repeat (5) tick;
      chk("t4_single_replay", busy, 0);

      // enable gating, and enable dropping mid-transaction
      en = 1'b0; intr = 1'b1;
      repeat (4) tick;
      chk("en_off_busy", busy, 0);
      intr = 1'b0; tick;
      en = 1'b1;
      repeat (3) tick;
      chk("en_not_latched", busy, 0);
      rdata = 32'h0006_0000; intr = 1'b1;
      tick;
      en = 1'b0; intr = 1'b0;
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      chk("en_mid_count", count, 4);
      chk("en_mid_cyc",   cyc,   0);
      en = 1'b1;

      // 5: periodic poll
      en_p = 1'b1;
      n = 0;
      while (starts_p < 3 && n < 100) begin
         tick;
         n++;
      end
      chk("t5_starts",   starts_p, 3);
      chk("t5_interval", last_start - prev_start, 16);
      en_p = 1'b0;
      repeat (8) tick;
      s = starts_p;
      repeat (40) tick;
      chk("t5_disabled_starts", starts_p, s);
      chk("t5_disabled_busy",   busy_p,   0);

      // 6: async reset in WR_WAIT, then a clean transaction
      rdata = 32'h0099_0000; intr = 1'b1;
      tick;
      intr = 1'b0;
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      tick;
      chk("t6_in_wrwait", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_cyc",   cyc,   0);
      chk("t6_rst_stb",   stb,   0);
      chk("t6_rst_busy",  busy,  0);
      chk("t6_rst_count", count, 0);
      tick; tick;
      rst_n = 1'b1; intr = 1'b1; rdata = 32'h00a5_0000;
      tick;
      chk("t6_sync_idle", busy, 0);
      n = 0;
      while (cyc !== 1'b1 && n < 10) begin
         tick;
         n++;
      end
      chk("t6_started", cyc, 1);
      intr = 1'b0;
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      tick;
      ack = 1'b1; tick; ack = 1'b0;
      chk("t6_count",  count,  1);
      chk("t6_status", status, 32'h00a5_0000);
      chk("t6_idle",   cyc,    0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
